// File: rtl/gpio_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_regfile_pkg
// Description : Shared constants for the GPIO command decoder / register file:
//               opcodes, command-word field positions, counter kind indices.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_regfile_pkg;

  // Command opcodes carried in i_gpio[OPC_MSB:OPC_LSB]
  localparam logic [7:0] OPC_RST   = 8'h01;
  localparam logic [7:0] OPC_LOG   = 8'h03;
  localparam logic [7:0] OPC_RAMRD = 8'h04;
  localparam logic [7:0] OPC_SNAP  = 8'h05;
  localparam logic [7:0] OPC_CNTRD = 8'h06;
  localparam logic [7:0] OPC_STAT  = 8'h07;

  // Command word layout: [31:24] opcode, [23] strobe, [22:0] payload
  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 24;
  localparam int STROBE_BIT = 23;

  // Counter kind within a channel's word group
  localparam int KIND_ERR = 0;
  localparam int KIND_BIT = 1;

  // Only recognised opcodes execute, pulse o_cmd_strobe and bump cmd_cnt
  function automatic logic opc_is_known(input logic [7:0] opc);
    logic known;
    known = 1'b0;
    case (opc)
      OPC_RST, OPC_LOG, OPC_RAMRD, OPC_SNAP, OPC_CNTRD, OPC_STAT: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_strobe_detect.sv
`default_nettype none
// ============================================================================
// Module      : gpio_strobe_detect
// Description : Registers the GPIO command word and emits a one-cycle execute
//               pulse on the rising edge of the strobe bit, together with the
//               command word that caused it. With GPIO_REGF_SYNC_EN defined
//               the word first passes a 2-flop synchroniser (one extra cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_strobe_detect
  import gpio_regfile_pkg::*;
#(
  parameter int NB_GPIO = 32
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_GPIO-1:0] i_gpio,
  output logic [NB_GPIO-1:0] o_cmd,
  output logic               o_exec
);

  logic [NB_GPIO-1:0] in_d, in_q;
  logic [NB_GPIO-1:0] cmd_d, cmd_q;
  logic               prev_d, prev_q;
  logic               exec_d, exec_q;

`ifdef GPIO_REGF_SYNC_EN
  logic [NB_GPIO-1:0] sync_d, sync_q;

  // First synchroniser stage; strobe resets high so a held strobe never fires
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q             <= '0;
      sync_q[STROBE_BIT] <= 1'b1;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    sync_d = i_gpio;
    in_d   = sync_q;
  end
`else
  always_comb begin
    in_d = i_gpio;
  end
`endif

  // Edge detect on the registered strobe; command word travels with the pulse
  always_comb begin
    prev_d = in_q[STROBE_BIT];
    exec_d = in_q[STROBE_BIT] & ~prev_q;
    cmd_d  = in_q;
  end

  // Input register and detector pipeline; strobe history resets to 1
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      in_q             <= '0;
      in_q[STROBE_BIT] <= 1'b1;
      prev_q           <= 1'b1;
      exec_q           <= 1'b0;
      cmd_q            <= '0;
    end else begin
      in_q   <= in_d;
      prev_q <= prev_d;
      exec_q <= exec_d;
      cmd_q  <= cmd_d;
    end
  end

  assign o_cmd  = cmd_q;
  assign o_exec = exec_q;

endmodule
`default_nettype wire

// File: rtl/gpio_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cmd_regfile
// Description : GPIO command decoder and register file. Executes one command
//               per strobe rising edge, drives soft-reset / logging / RAM-read
//               controls, snapshots N_CH error and bit counters into shadow
//               registers and muxes RAM data, counter words or status back
//               onto o_gpio. Optional macro GPIO_REGF_SYNC_EN adds an input
//               synchroniser (see gpio_strobe_detect).
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_cmd_regfile
  import gpio_regfile_pkg::*;
#(
  parameter int NB_GPIO = 32,
  parameter int NB_CNT  = 64,
  parameter int N_CH    = 2,
  parameter int NB_ADDR = 16
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic [NB_GPIO-1:0]     i_gpio,
  output logic [NB_GPIO-1:0]     o_gpio,
  input  logic [N_CH*NB_CNT-1:0] i_cnt_err,
  input  logic [N_CH*NB_CNT-1:0] i_cnt_bit,
  input  logic [NB_GPIO-1:0]     i_ram_data,
  output logic                   o_rst_soft,
  output logic [2:0]             o_log_sel,
  output logic                   o_log_wr_en,
  output logic                   o_ram_rd_en,
  output logic [NB_ADDR-1:0]     o_ram_addr,
  output logic                   o_cmd_strobe,
  output logic                   o_snap_valid
);

  localparam int WPC     = NB_CNT / NB_GPIO;
  localparam int N_WORDS = N_CH * 2 * WPC;
  localparam int NB_PAY  = STROBE_BIT;

  logic [NB_GPIO-1:0] w_cmd;
  logic               w_exec;
  logic [7:0]         w_opc;
  logic [NB_PAY-1:0]  w_pay;
  logic               w_run;
  logic               w_snap_load;
  logic               w_unused;

  gpio_strobe_detect #(.NB_GPIO(NB_GPIO)) u_strobe_detect (
    .clk     (clk),
    .i_reset (i_reset),
    .i_gpio  (i_gpio),
    .o_cmd   (w_cmd),
    .o_exec  (w_exec)
  );

  assign w_opc    = w_cmd[OPC_MSB:OPC_LSB];
  assign w_pay    = w_cmd[NB_PAY-1:0];
  assign w_run    = w_exec & opc_is_known(w_opc);
  assign w_unused = ^w_pay[NB_PAY-1:17];

  logic                   rst_soft_d,   rst_soft_q;
  logic [2:0]             log_sel_d,    log_sel_q;
  logic                   log_wr_en_d,  log_wr_en_q;
  logic                   ram_rd_en_d,  ram_rd_en_q;
  logic [NB_ADDR-1:0]     ram_addr_d,   ram_addr_q;
  logic                   cnt_rd_en_d,  cnt_rd_en_q;
  logic [15:0]            cnt_sel_d,    cnt_sel_q;
  logic                   stat_rd_en_d, stat_rd_en_q;
  logic                   cont_mode_d,  cont_mode_q;
  logic [15:0]            cmd_cnt_d,    cmd_cnt_q;
  logic                   cmd_strobe_d, cmd_strobe_q;
  logic                   snap_valid_d, snap_valid_q;
  logic [N_CH*NB_CNT-1:0] shd_err_d,    shd_err_q;
  logic [N_CH*NB_CNT-1:0] shd_bit_d,    shd_bit_q;

  // Command decode; continuous mode and a one-shot share one load strobe
  always_comb begin
    rst_soft_d   = rst_soft_q;
    log_sel_d    = log_sel_q;
    log_wr_en_d  = log_wr_en_q;
    ram_rd_en_d  = ram_rd_en_q;
    ram_addr_d   = ram_addr_q;
    cnt_rd_en_d  = cnt_rd_en_q;
    cnt_sel_d    = cnt_sel_q;
    stat_rd_en_d = stat_rd_en_q;
    cont_mode_d  = cont_mode_q;
    cmd_cnt_d    = cmd_cnt_q;
    w_snap_load  = cont_mode_q;
    if (w_run) begin
      cmd_cnt_d = cmd_cnt_q + 16'd1;
      case (w_opc)
        OPC_RST:   rst_soft_d = w_pay[0];
        OPC_LOG: begin
          log_sel_d   = w_pay[2:0];
          log_wr_en_d = w_pay[3];
        end
        OPC_RAMRD: begin
          ram_rd_en_d = w_pay[16];
          ram_addr_d  = w_pay[NB_ADDR-1:0];
        end
        OPC_SNAP: begin
          cont_mode_d = w_pay[1];
          if (w_pay[0]) w_snap_load = 1'b1;
        end
        OPC_CNTRD: begin
          cnt_rd_en_d = w_pay[16];
          cnt_sel_d   = w_pay[15:0];
        end
        OPC_STAT:  stat_rd_en_d = w_pay[0];
        default:   ;
      endcase
    end
    cmd_strobe_d = w_run;
    snap_valid_d = w_snap_load;
    shd_err_d    = w_snap_load ? i_cnt_err : shd_err_q;
    shd_bit_d    = w_snap_load ? i_cnt_bit : shd_bit_q;
  end

  // Control, mode and shadow state; soft reset is asserted out of reset
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      rst_soft_q   <= 1'b1;
      log_sel_q    <= '0;
      log_wr_en_q  <= 1'b0;
      ram_rd_en_q  <= 1'b0;
      ram_addr_q   <= '0;
      cnt_rd_en_q  <= 1'b0;
      cnt_sel_q    <= '0;
      stat_rd_en_q <= 1'b0;
      cont_mode_q  <= 1'b0;
      cmd_cnt_q    <= '0;
      cmd_strobe_q <= 1'b0;
      snap_valid_q <= 1'b0;
      shd_err_q    <= '0;
      shd_bit_q    <= '0;
    end else begin
      rst_soft_q   <= rst_soft_d;
      log_sel_q    <= log_sel_d;
      log_wr_en_q  <= log_wr_en_d;
      ram_rd_en_q  <= ram_rd_en_d;
      ram_addr_q   <= ram_addr_d;
      cnt_rd_en_q  <= cnt_rd_en_d;
      cnt_sel_q    <= cnt_sel_d;
      stat_rd_en_q <= stat_rd_en_d;
      cont_mode_q  <= cont_mode_d;
      cmd_cnt_q    <= cmd_cnt_d;
      cmd_strobe_q <= cmd_strobe_d;
      snap_valid_q <= snap_valid_d;
      shd_err_q    <= shd_err_d;
      shd_bit_q    <= shd_bit_d;
    end
  end

  // Flatten shadows into GPIO words: index ((ch*2 + kind)*WPC + word)
  logic [NB_GPIO-1:0] w_words [N_WORDS];
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    for (genvar wd = 0; wd < WPC; wd++) begin : g_wd
      assign w_words[(ch*2 + KIND_ERR)*WPC + wd] = shd_err_q[ch*NB_CNT + wd*NB_GPIO +: NB_GPIO];
      assign w_words[(ch*2 + KIND_BIT)*WPC + wd] = shd_bit_q[ch*NB_CNT + wd*NB_GPIO +: NB_GPIO];
    end
  end

  logic [NB_GPIO-1:0] w_cnt_word;
  logic [NB_GPIO-1:0] w_status;

  // Readback mux: RAM beats counters beats status; out-of-range selects read 0
  always_comb begin
    w_cnt_word = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (cnt_sel_q == 16'(i)) w_cnt_word = w_words[i];
    end
    w_status = {cmd_cnt_q, {(NB_GPIO-17){1'b0}}, cont_mode_q};
    if (ram_rd_en_q)       o_gpio = i_ram_data;
    else if (cnt_rd_en_q)  o_gpio = w_cnt_word;
    else if (stat_rd_en_q) o_gpio = w_status;
    else                   o_gpio = '0;
  end

  assign o_rst_soft   = rst_soft_q;
  assign o_log_sel    = log_sel_q;
  assign o_log_wr_en  = log_wr_en_q;
  assign o_ram_rd_en  = ram_rd_en_q;
  assign o_ram_addr   = ram_addr_q;
  assign o_cmd_strobe = cmd_strobe_q;
  assign o_snap_valid = snap_valid_q;

endmodule
`default_nettype wire

// File: doc/gpio_cmd_regfile.md
# gpio_cmd_regfile

Parametrised GPIO command decoder and register file between the MicroBlaze GPIO port and the DSP/logging datapath. It decodes opcode/strobe command words, drives the soft-reset, RAM-logging and RAM-read controls, and snapshots N_CH channels of error/bit counters into shadow registers. A readback mux returns RAM data, counter words or status on the GPIO input. Commands execute once per strobe rising edge, not on every cycle the strobe is high.

## Interface
- NB_GPIO, 32, GPIO word width
- NB_CNT, 64, counter width; must be a multiple of NB_GPIO
- N_CH, 2, counter channels (ch0 = I, ch1 = Q)
- NB_ADDR, 16, RAM read address width (≤ 16)
- clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_gpio  in  NB_GPIO  command word: [31:24] opcode, [23] strobe, [22:0] payload p
- o_gpio  out  NB_GPIO  readback word
- i_cnt_err  in  N_CH*NB_CNT  packed error counters, ch0 at LSBs
- i_cnt_bit  in  N_CH*NB_CNT  packed bit counters, ch0 at LSBs
- i_ram_data  in  NB_GPIO  RAM read data
- o_rst_soft  out  1  DSP soft reset
- o_log_sel  out  3  RAM log source select
- o_log_wr_en  out  1  RAM log write enable
- o_ram_rd_en  out  1  RAM read enable
- o_ram_addr  out  NB_ADDR  RAM read address
- o_cmd_strobe  out  1  one-cycle pulse per executed command
- o_snap_valid  out  1  high in every cycle a snapshot is loaded

## Operation
- Reset values: o_rst_soft = 1; all other outputs, shadow registers, mode bits and the command counter = 0.
- Execute = rising edge of registered strobe. Unknown opcode: ignored, no o_cmd_strobe, not counted.
- 0x01: o_rst_soft ← p[0].
- 0x03: o_log_sel ← p[2:0]; o_log_wr_en ← p[3].
- 0x04: o_ram_rd_en ← p[16]; o_ram_addr ← p[NB_ADDR-1:0].
- 0x05: p[0] = one-shot snapshot of all counters; cont_mode ← p[1]. While cont_mode = 1, capture every cycle.
- 0x06: cnt_rd_en ← p[16]; cnt_sel ← p[15:0].
- 0x07: stat_rd_en ← p[0].
- Counter word index: s = ((ch*2 + kind)*WPC + word), with WPC = NB_CNT/NB_GPIO, kind 0 = err / 1 = bit, word 0 = LSW. Default mapping: 0/1 errI lo/hi, 2/3 bitI, 4/5 errQ, 6/7 bitQ. s ≥ N_CH*2*WPC reads 0.
- Status word: {cmd_cnt[15:0], 15'b0, cont_mode}. cmd_cnt counts executed commands and wraps 0xFFFF→0.
- o_gpio priority: o_ram_rd_en → i_ram_data; else cnt_rd_en → shadow word; else stat_rd_en → status; else 0. Enabling one source never clears another.

## Timing
- i_gpio captured at edge k, effect registered at edge k+2. o_cmd_strobe and o_snap_valid are high in the cycle after k+2.
- Snapshot captures the i_cnt_* values sampled at the load edge. All channels are loaded on the same edge (atomic).
- A strobe held high executes once. Strobe must be sampled low for ≥1 cycle before the next execution.
- The strobe pipeline resets to 1, so a strobe held high through reset release does not execute.
- Reset mid-operation: asynchronous clear of all state, including cont_mode.
- One-shot together with cont_mode = 1: single snapshot path, no double pulse.
- o_gpio is combinational from registered state and i_ram_data (zero-cycle RAM passthrough).

## Configuration
- GPIO_REGF_SYNC_EN defined: i_gpio passes a 2-flop synchroniser before the strobe detector. Effect latency becomes k+3.
- Not defined: single input register only; latency k+2.

## Structure
- Package gpio_regfile_pkg holds:
  - opcode localparams OPC_RST = 8'h01, OPC_LOG = 8'h03, OPC_RAMRD = 8'h04, OPC_SNAP = 8'h05, OPC_CNTRD = 8'h06, OPC_STAT = 8'h07
  - field positions OPC_MSB = 31, OPC_LSB = 24, STROBE_BIT = 23
  - counter kind constants KIND_ERR = 0, KIND_BIT = 1
- Sub-module gpio_strobe_detect: input registers, optional synchroniser, rising-edge pulse.

## Test plan
- Reset, then read outputs → o_rst_soft = 1, all other outputs 0, o_gpio = 0.
- Write 0x0180_0000 held high for 10 cycles → o_rst_soft = 0 at k+2; o_cmd_strobe single pulse; cmd_cnt = 1.
- i_cnt_err = {Q: 64'h5, I: 64'h1_0000_0002}; send 0x0580_0001, then 0x0681_0001 → o_gpio = 0x0000_0001. Select 5 → 0x0000_0000; select 4 → 0x0000_0005.
- 0x0480_0000 + p[16] = 1, addr 0x0123, with counter read also enabled → o_ram_addr = 0x0123 and o_gpio = i_ram_data (RAM has priority).
- 0x0580_0002 → o_snap_valid high every cycle and shadow tracks a counter ramping 1 per cycle, one cycle behind. 0x0580_0000 → snapshot freezes.
- Opcode 0x09 strobed → no pulse, no state change, cmd_cnt unchanged. Strobe held through reset release → no execution.
